button_pulse: RTL

- Conditions a raw mechanical push-button input into clean control strobes for the sandbox counter stage: enable pulses and a debounced level.
- Sits directly upstream of the counter. `pulse` drives the counter's increment enable; `level` is available for a clear or status LED.
- Performs three functions:
  - 2-FF synchronisation of the asynchronous button.
  - Debounce via a consecutive-sample counter and FSM.
  - Optional auto-repeat while the button is held.

---
 rtl/button_pulse.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/button_pulse.sv
// ---------------------------------------------------------------------------
// button_pulse
//
// Turns a raw mechanical push-button into clean control strobes for the
// counter stage. The raw input is brought into the clock domain with a
// two-flop synchroniser. A consecutive-sample debounce FSM then filters it.
// While the button stays held, the block can optionally emit auto-repeat
// strobes.
//
// Parameters:
//   DB_CYCLES  - consecutive identical samples needed to accept a press or
//                a release (>= 1)
//   RPT_EN     - 1: auto-repeat while held, 0: one pulse per press
//   RPT_DELAY  - cycles from the press pulse to the first repeat (>= 1)
//   RPT_PERIOD - cycles between later repeats (>= 1)
//
// Ports:
//   clk    - posedge clock, the only clock domain
//   rst_n  - asynchronous active-low reset
//   btn_in - raw button, active high, asynchronous, may bounce
//   pulse  - registered one-cycle strobe per accepted press and per repeat
//   level  - registered debounced button state
// ---------------------------------------------------------------------------
module button_pulse #(
  parameter int DB_CYCLES  = 16,
  parameter int RPT_EN     = 1,
  parameter int RPT_DELAY  = 64,
  parameter int RPT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam int MAX_A     = (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
  localparam int MAX_CYC   = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
  localparam int CW        = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_T  = CW'(RPT_DELAY);
  localparam logic [CW-1:0] PERIOD_T = CW'(RPT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic          sync1;
  logic          sync2;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_next;
  logic [CW-1:0] rpt_cnt;
  logic [CW-1:0] rpt_next;
  logic          rpt_phase;
  logic          phase_next;
  logic          press_evt;
  logic          press_next;
  logic          rpt_hit;
  logic [CW-1:0] rpt_target;
  logic          s;

  // Two-flop synchroniser; only the second flop is seen by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;

  // The first repeat waits RPT_DELAY cycles. Later repeats use RPT_PERIOD.
  // The counter restarts at 1 on every hit, so it never exceeds its target.
  assign rpt_target = rpt_phase ? PERIOD_T : DELAY_T;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      state     <= state_next;
      db_cnt    <= db_next;
      rpt_cnt   <= rpt_next;
      rpt_phase <= phase_next;
      press_evt <= press_next;
    end
  end

  // Debounce and repeat scheduling. The sample that completes a run of
  // DB_CYCLES is the one for which db_cnt already holds DB_CYCLES-1.
  always_comb begin
    state_next = state;
    db_next    = db_cnt;
    rpt_next   = rpt_cnt;
    phase_next = rpt_phase;
    press_next = 1'b0;
    rpt_hit    = 1'b0;
    case (state)
      IDLE: begin
        db_next = '0;
        if (s) begin
          if (DB_CYCLES == 1) begin
            state_next = HELD;
            press_next = 1'b1;
            rpt_next   = '0;
            phase_next = 1'b0;
          end else begin
            state_next = PRESS_WAIT;
            db_next    = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          db_next    = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_next = HELD;
          db_next    = '0;
          press_next = 1'b1;
          rpt_next   = '0;
          phase_next = 1'b0;
        end else begin
          db_next = db_cnt + ONE;
        end
      end
      HELD: begin
        db_next = '0;
        if (!s) begin
          if (DB_CYCLES == 1) begin
            state_next = IDLE;
          end else begin
            state_next = RELEASE_WAIT;
            db_next    = ONE;
          end
        end else if (RPT_EN != 0) begin
          if (rpt_cnt == rpt_target) begin
            rpt_hit    = 1'b1;
            rpt_next   = ONE;
            phase_next = 1'b1;
          end else begin
            rpt_next = rpt_cnt + ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          // The button came back before the release was accepted, so the
          // repeat schedule starts over from the initial delay.
          state_next = HELD;
          db_next    = '0;
          rpt_next   = '0;
          phase_next = 1'b0;
        end else if (db_cnt >= DB_LAST) begin
          state_next = IDLE;
          db_next    = '0;
        end else begin
          db_next = db_cnt + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        db_next    = '0;
        rpt_next   = '0;
        phase_next = 1'b0;
      end
    endcase
  end

  // Registered outputs. The !pulse term ensures the strobe is never high
  // for two consecutive cycles, even with extreme repeat settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      pulse <= (press_evt || rpt_hit) && !pulse;
      level <= (state == HELD) || (state == RELEASE_WAIT);
    end
  end

endmodule
